// File: rtl/vga_timing_pkg.sv
// Shared timing constants, polarity encodings and geometry helpers for the
// VGA timing generator and its per-axis counters.
package vga_timing_pkg;

    localparam int SYNC_ACT_LOW  = 0;
    localparam int SYNC_ACT_HIGH = 1;

    typedef struct packed {
        int active;
        int fp;
        int pulse;
        int bp;
        int pol;
    } axis_timing_t;

    localparam axis_timing_t VGA_640X480_H = '{active: 640, fp: 16, pulse: 96, bp: 48, pol: SYNC_ACT_LOW};
    localparam axis_timing_t VGA_640X480_V = '{active: 480, fp: 10, pulse: 2,  bp: 33, pol: SYNC_ACT_LOW};
    localparam axis_timing_t VGA_800X600_H = '{active: 800, fp: 40, pulse: 128, bp: 88, pol: SYNC_ACT_HIGH};
    localparam axis_timing_t VGA_800X600_V = '{active: 600, fp: 1,  pulse: 4,   bp: 23, pol: SYNC_ACT_HIGH};

    function automatic int axis_blank(input int fp, input int pulse, input int bp);
        return fp + pulse + bp;
    endfunction

    function automatic int axis_total(input int active, input int fp, input int pulse, input int bp);
        return axis_blank(fp, pulse, bp) + active;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the sync generator to the pixel pipeline and pads.
interface vga_timing_gen_if #(
    parameter int CW  = 12,
    parameter int FCW = 8
);
    logic           hsync_o;
    logic           vsync_o;
    logic           activevideo_o;
    logic [CW-1:0]  x_px_o;
    logic [CW-1:0]  y_px_o;
    logic [CW-1:0]  hc_o;
    logic [CW-1:0]  vc_o;
    logic           line_start_o;
    logic           frame_start_o;
    logic [FCW-1:0] frame_cnt_o;

    modport master (
        output hsync_o, vsync_o, activevideo_o, x_px_o, y_px_o,
               hc_o, vc_o, line_start_o, frame_start_o, frame_cnt_o
    );

    modport slave (
        input hsync_o, vsync_o, activevideo_o, x_px_o, y_px_o,
              hc_o, vc_o, line_start_o, frame_start_o, frame_cnt_o
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus sync/active decode of the
// next count, so the parent can register decodes aligned with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int PULSE  = 96,
    parameter int BP     = 48,
    parameter int POL    = SYNC_ACT_LOW,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    output logic          wrap,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_next,
    output logic [CW-1:0] pos_next,
    output logic          sync_next,
    output logic          active_next
);
    localparam int BLANK = axis_blank(FP, PULSE, BP);
    localparam int TOTAL = axis_total(ACTIVE, FP, PULSE, BP);

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] SYNC_START = CW'(FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(FP + PULSE);
    localparam logic [CW-1:0] BLANK_C    = CW'(BLANK);
    localparam logic          SYNC_ON    = (POL != 0);

    if (ACTIVE < 1 || PULSE < 1) begin : g_bad_region
        $error("vga_axis_counter: active region and sync pulse must be non-empty");
    end
    if (CW < 2 || CW > 30 || TOTAL > (1 << CW)) begin : g_bad_width
        $error("vga_axis_counter: line/frame total does not fit in CW bits");
    end

    logic [CW-1:0] cnt_reg;

    always_comb begin
        wrap        = adv && (cnt_reg == LAST);
        cnt_next    = cnt_reg;
        if (wrap) begin
            cnt_next = '0;
        end else if (adv) begin
            cnt_next = cnt_reg + ONE;
        end
        sync_next   = (cnt_next >= SYNC_START && cnt_next < SYNC_END) ? SYNC_ON : ~SYNC_ON;
        active_next = (cnt_next >= BLANK_C);
        pos_next    = active_next ? (cnt_next - BLANK_C) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator: chained H/V counters advanced by a pixel
// strobe, with every output registered from the next-state counter values.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_640X480_H.active,
    parameter int H_FP        = VGA_640X480_H.fp,
    parameter int H_PULSE     = VGA_640X480_H.pulse,
    parameter int H_BP        = VGA_640X480_H.bp,
    parameter int V_ACTIVE    = VGA_640X480_V.active,
    parameter int V_FP        = VGA_640X480_V.fp,
    parameter int V_PULSE     = VGA_640X480_V.pulse,
    parameter int V_BP        = VGA_640X480_V.bp,
    parameter int HSYNC_POL   = SYNC_ACT_LOW,
    parameter int VSYNC_POL   = SYNC_ACT_LOW,
    parameter int ACTIVE_LEAD = 1,
    parameter int CW          = 12,
    parameter int FCW         = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             pix_en_i,
    vga_timing_gen_if.master vid
);
    localparam int H_BLANK = axis_blank(H_FP, H_PULSE, H_BP);

    localparam logic [CW-1:0]  AV_START = CW'(H_BLANK - ACTIVE_LEAD);
    localparam logic [FCW-1:0] FC_ONE   = FCW'(1);
    localparam logic           HS_IDLE  = (HSYNC_POL == 0);
    localparam logic           VS_IDLE  = (VSYNC_POL == 0);

    if (ACTIVE_LEAD < 0 || ACTIVE_LEAD >= H_BLANK) begin : g_bad_lead
        $error("vga_timing_gen: ACTIVE_LEAD must lie in 0..H_BLANK-1");
    end
    if (FCW < 1) begin : g_bad_fcw
        $error("vga_timing_gen: frame counter needs at least one bit");
    end

    logic          h_wrap, v_wrap;
    logic          h_sync_next, v_sync_next;
    logic          h_act_next, v_act_next;
    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] h_cnt_next, v_cnt_next;
    logic [CW-1:0] h_pos_next, v_pos_next;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .PULSE(H_PULSE), .BP(H_BP),
        .POL(HSYNC_POL), .CW(CW)
    ) u_h_cnt (
        .clk(clk_i), .rst_n(rstn_i), .adv(pix_en_i),
        .wrap(h_wrap), .cnt(h_cnt), .cnt_next(h_cnt_next), .pos_next(h_pos_next),
        .sync_next(h_sync_next), .active_next(h_act_next)
    );

    // The vertical axis steps only on the horizontal wrap.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .PULSE(V_PULSE), .BP(V_BP),
        .POL(VSYNC_POL), .CW(CW)
    ) u_v_cnt (
        .clk(clk_i), .rst_n(rstn_i), .adv(h_wrap),
        .wrap(v_wrap), .cnt(v_cnt), .cnt_next(v_cnt_next), .pos_next(v_pos_next),
        .sync_next(v_sync_next), .active_next(v_act_next)
    );

    logic           visible_next;
    logic           av_next;
    logic           hsync_reg, vsync_reg, av_reg, ls_reg, fs_reg;
    logic [CW-1:0]  x_reg, y_reg;
    logic [FCW-1:0] fc_reg;

    assign visible_next = h_act_next && v_act_next;
    assign av_next      = (h_cnt_next >= AV_START) && v_act_next;

    // Pulses come straight from the wrap decodes, so they drop on the next
    // clock even when the strobe is slower than the clock.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hsync_reg <= HS_IDLE;
            vsync_reg <= VS_IDLE;
            av_reg    <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            ls_reg    <= 1'b0;
            fs_reg    <= 1'b0;
            fc_reg    <= '0;
        end else begin
            hsync_reg <= h_sync_next;
            vsync_reg <= v_sync_next;
            av_reg    <= av_next;
            x_reg     <= visible_next ? h_pos_next : '0;
            y_reg     <= visible_next ? v_pos_next : '0;
            ls_reg    <= h_wrap;
            fs_reg    <= v_wrap;
            if (v_wrap) begin
                fc_reg <= fc_reg + FC_ONE;
            end
        end
    end

    assign vid.hsync_o       = hsync_reg;
    assign vid.vsync_o       = vsync_reg;
    assign vid.activevideo_o = av_reg;
    assign vid.x_px_o        = x_reg;
    assign vid.y_px_o        = y_reg;
    assign vid.hc_o          = h_cnt;
    assign vid.vc_o          = v_cnt;
    assign vid.line_start_o  = ls_reg;
    assign vid.frame_start_o = fs_reg;
    assign vid.frame_cnt_o   = fc_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny instance,
// each checked every clock against a queued reference, plus directed checks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        av;
        logic        ls;
        logic        fs;
        logic [11:0] hc;
        logic [11:0] vc;
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  fc;
    } obs_t;

    logic clk    = 1'b0;
    logic rstn_d = 1'b0;
    logic rstn_s = 1'b0;
    logic en_d   = 1'b0;
    logic en_s   = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(12), .FCW(8)) vid_d ();
    vga_timing_gen_if #(.CW(12), .FCW(2)) vid_s ();

    vga_timing_gen #(.CW(12), .FCW(8)) dut_d (
        .clk_i(clk), .rstn_i(rstn_d), .pix_en_i(en_d), .vid(vid_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_PULSE(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_PULSE(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(0), .ACTIVE_LEAD(0), .CW(12), .FCW(2)
    ) dut_s (
        .clk_i(clk), .rstn_i(rstn_s), .pix_en_i(en_s), .vid(vid_s)
    );

    int errors = 0;
    int checks = 0;

    obs_t q_d[$];
    obs_t q_s[$];

    int m_hc_d = 0, m_vc_d = 0, m_fc_d = 0;
    bit m_ls_d = 0, m_fs_d = 0;
    int m_hc_s = 0, m_vc_s = 0, m_fc_s = 0;
    bit m_ls_s = 0, m_fs_s = 0;

    function automatic obs_t obs_d();
        obs_t o;
        o.hs = vid_d.hsync_o;      o.vs = vid_d.vsync_o;  o.av = vid_d.activevideo_o;
        o.ls = vid_d.line_start_o; o.fs = vid_d.frame_start_o;
        o.hc = vid_d.hc_o;         o.vc = vid_d.vc_o;
        o.x  = vid_d.x_px_o;       o.y  = vid_d.y_px_o;   o.fc = vid_d.frame_cnt_o;
        return o;
    endfunction

    function automatic obs_t obs_s();
        obs_t o;
        o.hs = vid_s.hsync_o;      o.vs = vid_s.vsync_o;  o.av = vid_s.activevideo_o;
        o.ls = vid_s.line_start_o; o.fs = vid_s.frame_start_o;
        o.hc = vid_s.hc_o;         o.vc = vid_s.vc_o;
        o.x  = vid_s.x_px_o;       o.y  = vid_s.y_px_o;   o.fc = {6'd0, vid_s.frame_cnt_o};
        return o;
    endfunction

    function automatic obs_t model(input int hc, input int vc, input int fc, input bit ls, input bit fs,
                                   input int hfp, input int hp, input int hbp,
                                   input int vfp, input int vp, input int vbp,
                                   input bit hpol, input bit vpol, input int lead);
        obs_t e;
        int   hb = hfp + hp + hbp;
        int   vb = vfp + vp + vbp;
        bit   vis = (hc >= hb) && (vc >= vb);
        e.hs = (hc >= hfp && hc < hfp + hp) ? hpol : ~hpol;
        e.vs = (vc >= vfp && vc < vfp + vp) ? vpol : ~vpol;
        e.av = (hc >= hb - lead) && (vc >= vb);
        e.ls = ls;
        e.fs = fs;
        e.hc = 12'(hc);
        e.vc = 12'(vc);
        e.x  = vis ? 12'(hc - hb) : 12'd0;
        e.y  = vis ? 12'(vc - vb) : 12'd0;
        e.fc = 8'(fc);
        return e;
    endfunction

    task automatic advance(inout int hc, inout int vc, inout int fc, output bit ls, output bit fs,
                           input bit en, input int ht, input int vt, input int fmod);
        ls = 1'b0;
        fs = 1'b0;
        if (en) begin
            if (hc == ht - 1) begin
                hc = 0;
                ls = 1'b1;
                if (vc == vt - 1) begin
                    vc = 0;
                    fs = 1'b1;
                    fc = (fc + 1) % fmod;
                end else begin
                    vc = vc + 1;
                end
            end else begin
                hc = hc + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_obs(input string tag, input obs_t obs, input obs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive enables, queue the reference, compare after the edge.
    task automatic tick(input bit ed, input bit es);
        en_d = ed;
        en_s = es;
        if (rstn_d) begin
            advance(m_hc_d, m_vc_d, m_fc_d, m_ls_d, m_fs_d, ed, 800, 525, 256);
        end else begin
            m_hc_d = 0; m_vc_d = 0; m_fc_d = 0; m_ls_d = 0; m_fs_d = 0;
        end
        if (rstn_s) begin
            advance(m_hc_s, m_vc_s, m_fc_s, m_ls_s, m_fs_s, es, 14, 7, 4);
        end else begin
            m_hc_s = 0; m_vc_s = 0; m_fc_s = 0; m_ls_s = 0; m_fs_s = 0;
        end
        q_d.push_back(model(m_hc_d, m_vc_d, m_fc_d, m_ls_d, m_fs_d, 16, 96, 48, 10, 2, 33, 1'b0, 1'b0, 1));
        q_s.push_back(model(m_hc_s, m_vc_s, m_fc_s, m_ls_s, m_fs_s, 2, 2, 2, 1, 1, 1, 1'b1, 1'b0, 0));
        @(posedge clk);
        #1;
        chk_obs("sb_default", obs_d(), q_d.pop_front());
        chk_obs("sb_small", obs_s(), q_s.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t rst_exp;
        int   ls_cnt;
        int   hs_hi, hs_bad, first_hs, vs_lo, first_av_h, first_av_v, fs_cnt, first_fs;

        // Reset state of both instances
        tick(0, 0);
        tick(0, 0);
        chk("rst_hc", vid_d.hc_o, 0);
        chk("rst_hsync_low_pol", vid_d.hsync_o, 1);
        chk("rst_vsync_low_pol", vid_d.vsync_o, 1);
        chk("rst_hsync_high_pol", vid_s.hsync_o, 0);
        chk("rst_active", vid_d.activevideo_o, 0);
        chk("rst_line_start", vid_d.line_start_o, 0);
        chk("rst_frame_cnt", vid_d.frame_cnt_o, 0);
        rstn_d = 1'b1;
        rstn_s = 1'b1;

        // First line: hsync window and line wrap
        for (int i = 1; i <= 801; i++) begin
            tick(1, 0);
            if (i == 15)  chk("hsync_hc15", vid_d.hsync_o, 1);
            if (i == 16)  chk("hsync_hc16", vid_d.hsync_o, 0);
            if (i == 111) chk("hsync_hc111", vid_d.hsync_o, 0);
            if (i == 112) chk("hsync_hc112", vid_d.hsync_o, 1);
            if (i == 799) chk("ls_before_wrap", vid_d.line_start_o, 0);
            if (i == 800) begin
                chk("wrap_hc", vid_d.hc_o, 0);
                chk("wrap_vc", vid_d.vc_o, 1);
                chk("ls_at_wrap", vid_d.line_start_o, 1);
            end
            if (i == 801) chk("ls_one_clk", vid_d.line_start_o, 0);
        end

        // First visible line: lead pixel, first pixel, last pixel
        for (int n = 0; n < 40000 && !(m_vc_d == 45 && m_hc_d == 158); n++) tick(1, 0);
        chk("reach_v45_h158", vid_d.hc_o, 158);
        chk("av_h158", vid_d.activevideo_o, 0);
        tick(1, 0);
        chk("av_lead_h159", vid_d.activevideo_o, 1);
        chk("x_lead_h159", vid_d.x_px_o, 0);
        tick(1, 0);
        chk("x_h160", vid_d.x_px_o, 0);
        chk("y_v45", vid_d.y_px_o, 0);
        tick(1, 0);
        chk("x_h161", vid_d.x_px_o, 1);
        for (int n = 0; n < 1000 && m_hc_d != 799; n++) tick(1, 0);
        chk("x_h799", vid_d.x_px_o, 639);
        for (int n = 0; n < 1000 && !(m_vc_d == 46 && m_hc_d == 300); n++) tick(1, 0);
        chk("x_h300", vid_d.x_px_o, 140);
        chk("y_v46", vid_d.y_px_o, 1);

        // Asynchronous reset mid-line, checked before the next clock edge
        rstn_d = 1'b0;
        #2;
        rst_exp    = '0;
        rst_exp.hs = 1'b1;
        rst_exp.vs = 1'b1;
        chk_obs("async_reset", obs_d(), rst_exp);
        chk("async_reset_vc", vid_d.vc_o, 0);
        m_hc_d = 0; m_vc_d = 0; m_fc_d = 0; m_ls_d = 0; m_fs_d = 0;
        tick(1, 0);
        rstn_d = 1'b1;
        tick(1, 0);
        chk("restart_hc", vid_d.hc_o, 1);
        chk("restart_vc", vid_d.vc_o, 0);

        // Half-rate strobe across a line wrap
        for (int n = 0; n < 1000 && m_hc_d != 795; n++) tick(1, 0);
        ls_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick((k % 2) == 0, 0);
            ls_cnt += int'(vid_d.line_start_o);
        end
        chk("ls_cycles_half_rate", ls_cnt, 1);
        chk("half_rate_hc", vid_d.hc_o, 3);
        chk("half_rate_vc", vid_d.vc_o, 1);

        // Small geometry: four full frames
        hs_hi = 0; hs_bad = 0; first_hs = -1; vs_lo = 0;
        first_av_h = -1; first_av_v = -1; fs_cnt = 0; first_fs = -1;
        for (int i = 1; i <= 392; i++) begin
            tick(0, 1);
            if (vid_s.hsync_o) begin
                if (first_hs < 0) first_hs = int'(vid_s.hc_o);
                if (vid_s.hc_o < 2 || vid_s.hc_o > 3) hs_bad++;
                if (i <= 14) hs_hi++;
            end
            if (i <= 98 && !vid_s.vsync_o) vs_lo++;
            if (vid_s.activevideo_o && first_av_h < 0) begin
                first_av_h = int'(vid_s.hc_o);
                first_av_v = int'(vid_s.vc_o);
            end
            if (vid_s.frame_start_o) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = i;
            end
            if (i == 98)  chk("small_fc_frame1", vid_s.frame_cnt_o, 1);
            if (i == 294) chk("small_fc_frame3", vid_s.frame_cnt_o, 3);
        end
        chk("small_first_hsync_hc", first_hs, 2);
        chk("small_hsync_width", hs_hi, 2);
        chk("small_hsync_outside", hs_bad, 0);
        chk("small_vsync_low_clks", vs_lo, 14);
        chk("small_first_av_hc", first_av_h, 6);
        chk("small_first_av_vc", first_av_v, 3);
        chk("small_first_fs_strobe", first_fs, 98);
        chk("small_fs_count", fs_cnt, 4);
        chk("small_fc_wrap", vid_s.frame_cnt_o, 0);
        chk("small_fs_at_wrap", vid_s.frame_start_o, 1);
        tick(0, 1);
        chk("small_fs_one_clk", vid_s.frame_start_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
